// File: rtl/upe_accum64.sv
// upe_accum64: frame accumulator for signed 32-bit terms into a 64-bit sum.
// Each term is added in two beats: the low word in LO (carry registered) and
// the sign-extended high word in HI, so the carry chain is only 33 bits long.
// A frame closes on in_last; the result is held in DONE until out_ready.
module upe_accum64 #(
    parameter int COUNT_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        out_sum,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_overflow
);

    typedef enum logic [1:0] {LO, HI, DONE} state_t;

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t              state_reg;
    logic [63:0]         acc_reg;
    logic                carry_reg;
    logic                sign_reg;
    logic                last_reg;
    logic [COUNT_W-1:0]  count_reg;
    logic                overflow_reg;
    logic                out_valid_reg;

    logic [32:0]         lo_sum;
    logic [31:0]         hi_sum;
    logic                hi_ovf;

    // Low-word add including its carry out, and the high-word add of the
    // sign extension plus that carry. Overflow: operands agree in sign but
    // the new top bit does not.
    assign lo_sum = {1'b0, acc_reg[31:0]} + {1'b0, in_data};
    assign hi_sum = acc_reg[63:32] + {32{sign_reg}} + {31'b0, carry_reg};
    assign hi_ovf = (acc_reg[63] == sign_reg) && (hi_sum[31] != sign_reg);

    // Terms are only taken in LO, and never while reset is asserted.
    assign in_ready = (state_reg == LO) && !RST;

    assign out_valid    = out_valid_reg;
    assign out_sum      = acc_reg;
    assign out_count    = count_reg;
    assign out_overflow = overflow_reg;

    // Two-beat accumulate FSM with result hold until the consumer accepts it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= LO;
            acc_reg       <= '0;
            carry_reg     <= 1'b0;
            sign_reg      <= 1'b0;
            last_reg      <= 1'b0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                LO: begin
                    if (in_valid && in_ready) begin
                        acc_reg[31:0] <= lo_sum[31:0];
                        carry_reg     <= lo_sum[32];
                        sign_reg      <= in_data[31];
                        last_reg      <= in_last;
                        if (count_reg != COUNT_MAX) begin
                            count_reg <= count_reg + COUNT_ONE;
                        end
                        state_reg     <= HI;
                    end
                end
                HI: begin
                    acc_reg[63:32] <= hi_sum;
                    carry_reg      <= 1'b0;
                    if (hi_ovf) begin
                        overflow_reg <= 1'b1;
                    end
                    if (last_reg) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        state_reg     <= LO;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_reg       <= '0;
                        count_reg     <= '0;
                        overflow_reg  <= 1'b0;
                        carry_reg     <= 1'b0;
                        sign_reg      <= 1'b0;
                        last_reg      <= 1'b0;
                        out_valid_reg <= 1'b0;
                        state_reg     <= LO;
                    end
                end
                default: begin
                    state_reg     <= LO;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upe_accum64.sv
// Directed bench for upe_accum64 with a reference model and result scoreboard.
module tb_upe_accum64;

    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_sum;
    logic [CW-1:0] out_count;
    logic          out_overflow;

    upe_accum64 #(.COUNT_W(CW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0]   sum;
        logic [CW-1:0] cnt;
        logic          ovf;
    } exp_t;

    exp_t          sb_q[$];
    logic [63:0]   m_sum;
    logic [CW-1:0] m_cnt;
    logic          m_ovf;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_sum = '0;
        m_cnt = '0;
        m_ovf = 1'b0;
    endtask

    // Reference: full 64-bit signed add of the sign-extended term.
    task automatic model_add(input logic [31:0] d, input logic l);
        logic [63:0] b;
        logic [63:0] s;
        exp_t e;
        b = {{32{d[31]}}, d};
        s = m_sum + b;
        if ((m_sum[63] == b[63]) && (s[63] != m_sum[63])) m_ovf = 1'b1;
        m_sum = s;
        if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
        if (l) begin
            e.sum = m_sum;
            e.cnt = m_cnt;
            e.ovf = m_ovf;
            sb_q.push_back(e);
        end
    endtask

    // Starts and ends at a negedge; returns in the HI cycle of this term.
    task automatic send(input logic [31:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("in_ready_wait", {63'b0, in_ready}, 64'd1);
        @(posedge CLK);
        model_add(d, l);
        @(negedge CLK);
        in_valid = 1'b0;
        check("in_ready_hi", {63'b0, in_ready}, 64'd0);
        check("out_valid_hi", {63'b0, out_valid}, 64'd0);
    endtask

    // Waits for a result, compares against the scoreboard, then handshakes.
    task automatic recv();
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("out_valid_wait", {63'b0, out_valid}, 64'd1);
        check("sb_nonempty", {63'b0, (sb_q.size() != 0)}, 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("out_sum", out_sum, e.sum);
            check("out_count", {{(64-CW){1'b0}}, out_count}, {{(64-CW){1'b0}}, e.cnt});
            check("out_overflow", {63'b0, out_overflow}, {63'b0, e.ovf});
            $display("frame sum=%016h count=%0d ovf=%0b", out_sum, out_count, out_overflow);
        end
        out_ready = 1'b1;
        @(posedge CLK);
        model_clear();
        @(negedge CLK);
        out_ready = 1'b0;
        check("drained_valid", {63'b0, out_valid}, 64'd0);
        check("drained_sum", out_sum, 64'd0);
        check("drained_count", {{(64-CW){1'b0}}, out_count}, 64'd0);
        check("drained_ovf", {63'b0, out_overflow}, 64'd0);
        check("drained_ready", {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        RST       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_clear();

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_in_ready", {63'b0, in_ready}, 64'd0);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_sum", out_sum, 64'd0);
        check("rst_out_count", {{(64-CW){1'b0}}, out_count}, 64'd0);
        check("rst_out_ovf", {63'b0, out_overflow}, 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_in_ready", {63'b0, in_ready}, 64'd1);

        // 5, -3, 10 with latency check on the last term
        out_ready = 1'b1;
        send(32'd5, 1'b0);
        send(32'hFFFF_FFFD, 1'b0);
        send(32'd10, 1'b1);
        @(negedge CLK);
        check("latency_valid", {63'b0, out_valid}, 64'd1);
        check("s1_sum_const", out_sum, 64'd12);
        recv();

        // -1 + 1: carry out of the low word cancels the sign extension
        send(32'hFFFF_FFFF, 1'b0);
        send(32'd1, 1'b1);
        recv();

        // 4 x 0x7FFFFFFF then 0x80000000: carry into upper word
        for (int i = 0; i < 4; i++) send(32'h7FFF_FFFF, 1'b0);
        send(32'h8000_0000, 1'b1);
        @(negedge CLK);
        check("s3_sum_const", out_sum, 64'h0000_0001_7FFF_FFFC);
        recv();

        // Idle in LO holds the accumulator across a stalled open frame
        send(32'd9, 1'b0);
        repeat (6) @(negedge CLK);
        check("stall_sum", out_sum, 64'd9);
        check("stall_ready", {63'b0, in_ready}, 64'd1);
        send(32'd1, 1'b1);
        recv();

        // Count saturation, then forced near-max sum to provoke overflow
        for (int i = 0; i < 260; i++) send(32'h7FFF_FFFF, 1'b0);
        @(negedge CLK);
        check("sat_count", {{(64-CW){1'b0}}, out_count}, 64'd255);
        force dut.acc_reg = 64'h7FFF_FFFF_FFFF_FFFF;
        #1;
        release dut.acc_reg;
        m_sum = 64'h7FFF_FFFF_FFFF_FFFF;
        send(32'd1, 1'b0);
        @(negedge CLK);
        check("ovf_set", {63'b0, out_overflow}, 64'd1);
        send(32'd2, 1'b1);
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            check("ovf_hold", {63'b0, out_overflow}, 64'd1);
            @(negedge CLK);
        end
        recv();

        // Back-pressure in DONE for 10 cycles, in_valid must be ignored
        send(32'd40, 1'b0);
        send(32'hFFFF_FFF6, 1'b1);
        @(negedge CLK);
        e = sb_q[0];
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd99;
            in_last  = 1'b1;
            check("bp_valid", {63'b0, out_valid}, 64'd1);
            check("bp_in_ready", {63'b0, in_ready}, 64'd0);
            check("bp_sum", out_sum, e.sum);
            @(negedge CLK);
        end
        in_valid = 1'b0;
        recv();
        send(32'd7, 1'b1);
        recv();

        // Reset during HI of the 2nd term aborts the frame
        send(32'd100, 1'b0);
        send(32'd200, 1'b1);
        RST      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd5;
        in_last  = 1'b1;
        @(negedge CLK);
        check("rst_hi_ready", {63'b0, in_ready}, 64'd0);
        check("rst_hi_valid", {63'b0, out_valid}, 64'd0);
        check("rst_hi_sum", out_sum, 64'd0);
        @(negedge CLK);
        RST      = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        model_clear();
        for (int i = 0; i < 4; i++) begin
            check("abort_no_valid", {63'b0, out_valid}, 64'd0);
            @(negedge CLK);
        end
        check("abort_sum", out_sum, 64'd0);
        send(32'd2, 1'b1);
        recv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/upe_accum64.md
UPE_ACCUM64 -- requirements
Module: upe_accum64

Interface
REQ-001 The block SHALL have parameter COUNT_W, default 8, the width of the term counter.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a term this cycle.
REQ-006 The block SHALL have port in_data, input, 32 bits: signed two's-complement term, for example a product from the upstream multiply stage.
REQ-007 The block SHALL have port in_last, input, 1 bit: this term closes the frame.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the frame result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer, a 64-bit add stage, accepts the result.
REQ-010 The block SHALL have port out_sum, output, 64 bits: signed frame sum.
REQ-011 The block SHALL have port out_count, output, COUNT_W bits: number of terms in the frame, saturating.
REQ-012 The block SHALL have port out_overflow, output, 1 bit: sticky signed 64-bit overflow flag for the frame.

Function
REQ-013 The block SHALL implement the FSM states LO, HI and DONE; the reset state SHALL be LO.
REQ-014 in_ready SHALL be 1 only when state is LO and RST is 0, combinationally.
REQ-015 Transfer in LO (in_valid and in_ready both 1): acc[31:0] <= acc[31:0] + in_data; the 33rd bit SHALL be registered as carry; in_data[31] and in_last SHALL be registered; next state SHALL be HI.
REQ-016 In HI the block SHALL compute acc[63:32] <= acc[63:32] + {32{sign}} + carry.
REQ-017 In HI, if the registered last flag is 1, the next state SHALL be DONE; otherwise it SHALL be LO.
REQ-018 Throughput SHALL be one term per 2 cycles.
REQ-019 Latency from the transfer of the last term to out_valid=1 SHALL be 2 cycles.
REQ-020 In LO with in_valid=0, the block SHALL hold state and the accumulator SHALL be unchanged.
REQ-021 The term count SHALL increment on each LO transfer and saturate at 2^COUNT_W-1 without wrap.
REQ-022 Overflow SHALL be set in HI when the signs of the old acc[63] and of the addend are equal and the sign of the new acc[63] differs; it SHALL stay set until the frame is drained.
REQ-023 The accumulator SHALL wrap modulo 2^64 on overflow; no saturation of out_sum.
REQ-024 In DONE: out_valid SHALL be 1; out_sum, out_count and out_overflow SHALL be held stable while out_ready is 0.
REQ-025 In DONE with out_ready=1: acc, count, overflow and carry SHALL clear to 0 and next state SHALL be LO; the next term is accepted no earlier than the following cycle.
REQ-026 out_valid SHALL be 0 in LO and HI.
REQ-027 out_sum, out_count and out_overflow SHALL reflect the internal registers in all states; they are meaningful only when out_valid=1.
REQ-028 in_valid SHALL be ignored outside LO.
REQ-029 A frame of one term with in_last=1 SHALL be legal.
REQ-030 A term with in_last=0 followed by an indefinite stall SHALL keep the frame open.

Reset
REQ-031 With RST=1 at a rising edge: state SHALL go to LO; acc, carry, sign, last, count and overflow SHALL go to 0.
REQ-032 Reset values SHALL be out_valid=0, out_sum=0, out_count=0, out_overflow=0.
REQ-033 in_ready SHALL be 0 while RST=1.
REQ-034 Reset in HI or DONE SHALL abort the frame; the partial sum SHALL be discarded and never presented.
REQ-035 A term presented in the reset cycle SHALL NOT be accepted.

Verification
REQ-036 Scenario: terms 5, -3, 10 (last on 10), out_ready=1 -> out_valid on the 2nd cycle after the 3rd transfer; out_sum=12; out_count=3; out_overflow=0; in_ready is 0 on every HI cycle.
REQ-037 Scenario: terms 0xFFFFFFFF (-1) and 1 (last) -> out_sum=0; the carry from the low half is consumed correctly; the upper word is 0x00000000.
REQ-038 Scenario: terms 0x7FFFFFFF x4 then 0x80000000 (last) -> out_sum=0x00000001_7FFFFFFC; the carry crosses into the upper word; out_count=5.
REQ-039 Scenario: preload acc near 2^63 with 2^32 terms of 0x7FFFFFFF, using COUNT_W=8 -> out_count saturates at 255; overflow is checked with a forced sum; out_overflow=1 and stays 1 until the handshake.
REQ-040 Scenario: out_ready held 0 for 10 cycles in DONE -> outputs are stable; in_ready=0; after the handshake, acc=0 and the next frame of a single term 7 gives out_sum=7.
REQ-041 Scenario: RST asserted in the HI cycle of the 2nd term -> out_valid is never raised; after reset, frame {2 (last)} gives out_sum=2 and out_count=1.
